// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read/write arbiters.
// Holds the arbiter FSM encoding and the 2-way round-robin pick rule.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_AR   = 2'd1,
      ARB_R    = 2'd2
   } arb_state_t;

   // On a tie the requester that did not win last time goes next.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req[0] && req[1]) begin
         return ~last;
      end else if (req[1]) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Two-requester round-robin arbiter: request vector plus last grant index in,
// one-hot grant out. Purely combinational so the caller decides when to latch it.
module axi_rr_arbiter
   import axi_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   logic w_pick;

   always_comb begin
      w_pick  = rr_pick(i_req, i_last);
      o_grant = 2'b00;
      if (|i_req) begin
         o_grant[w_pick] = 1'b1;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Shares one AXI4 read port between two masters, one burst in flight at a time.
// AR and R paths are combinational muxes steered by the registered owner.
module axi_rd_arbiter_2to1
   import axi_arb_pkg::*;
#(
   parameter int ID_WIDTH   = 10,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   // master 0
   input  logic [ID_WIDTH-1:0]   s0_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
   input  logic [7:0]            s0_axi_arlen,
   input  logic [2:0]            s0_axi_arsize,
   input  logic [1:0]            s0_axi_arburst,
   input  logic [USER_WIDTH-1:0] s0_axi_aruser,
   input  logic                  s0_axi_arvalid,
   output logic                  s0_axi_arready,
   output logic [ID_WIDTH-1:0]   s0_axi_rid,
   output logic [DATA_WIDTH-1:0] s0_axi_rdata,
   output logic [1:0]            s0_axi_rresp,
   output logic                  s0_axi_rlast,
   output logic [USER_WIDTH-1:0] s0_axi_ruser,
   output logic                  s0_axi_rvalid,
   input  logic                  s0_axi_rready,
   // master 1
   input  logic [ID_WIDTH-1:0]   s1_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
   input  logic [7:0]            s1_axi_arlen,
   input  logic [2:0]            s1_axi_arsize,
   input  logic [1:0]            s1_axi_arburst,
   input  logic [USER_WIDTH-1:0] s1_axi_aruser,
   input  logic                  s1_axi_arvalid,
   output logic                  s1_axi_arready,
   output logic [ID_WIDTH-1:0]   s1_axi_rid,
   output logic [DATA_WIDTH-1:0] s1_axi_rdata,
   output logic [1:0]            s1_axi_rresp,
   output logic                  s1_axi_rlast,
   output logic [USER_WIDTH-1:0] s1_axi_ruser,
   output logic                  s1_axi_rvalid,
   input  logic                  s1_axi_rready,
   // slave side
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [USER_WIDTH-1:0] m_axi_aruser,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic [USER_WIDTH-1:0] m_axi_ruser,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   // status
   output logic                  busy,
   output logic                  owner,
   output logic                  len_err
);

   arb_state_t r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic [7:0] r_len_q, w_len_q_nxt;
   logic [7:0] r_beat_cnt, w_beat_cnt_nxt;
   logic       r_len_err, w_len_err_nxt;
   logic [1:0] w_req;
   logic [1:0] w_grant;
   logic       w_gnt_idx;
   logic       w_ar_hs;
   logic       w_r_hs;

   assign w_req = {s1_axi_arvalid, s0_axi_arvalid};

   axi_rr_arbiter u_rr (
      .i_req   (w_req),
      .i_last  (r_owner),
      .o_grant (w_grant)
   );

   assign w_gnt_idx = w_grant[1];
   assign w_ar_hs   = m_axi_arvalid & m_axi_arready;
   assign w_r_hs    = m_axi_rvalid & m_axi_rready;

   // Channel steering: AR only in ARB_AR, R only in ARB_R, non-owner sees zeros.
   always_comb begin
      m_axi_arid     = s0_axi_arid;
      m_axi_araddr   = s0_axi_araddr;
      m_axi_arlen    = s0_axi_arlen;
      m_axi_arsize   = s0_axi_arsize;
      m_axi_arburst  = s0_axi_arburst;
      m_axi_aruser   = s0_axi_aruser;
      m_axi_arvalid  = 1'b0;
      s0_axi_arready = 1'b0;
      s1_axi_arready = 1'b0;
      s0_axi_rid     = '0;
      s0_axi_rdata   = '0;
      s0_axi_rresp   = '0;
      s0_axi_rlast   = 1'b0;
      s0_axi_ruser   = '0;
      s0_axi_rvalid  = 1'b0;
      s1_axi_rid     = '0;
      s1_axi_rdata   = '0;
      s1_axi_rresp   = '0;
      s1_axi_rlast   = 1'b0;
      s1_axi_ruser   = '0;
      s1_axi_rvalid  = 1'b0;
      m_axi_rready   = 1'b0;
      case (r_state)
         ARB_AR: begin
            if (r_owner) begin
               m_axi_arid     = s1_axi_arid;
               m_axi_araddr   = s1_axi_araddr;
               m_axi_arlen    = s1_axi_arlen;
               m_axi_arsize   = s1_axi_arsize;
               m_axi_arburst  = s1_axi_arburst;
               m_axi_aruser   = s1_axi_aruser;
               m_axi_arvalid  = s1_axi_arvalid;
               s1_axi_arready = m_axi_arready;
            end else begin
               m_axi_arvalid  = s0_axi_arvalid;
               s0_axi_arready = m_axi_arready;
            end
         end
         ARB_R: begin
            if (r_owner) begin
               s1_axi_rid    = m_axi_rid;
               s1_axi_rdata  = m_axi_rdata;
               s1_axi_rresp  = m_axi_rresp;
               s1_axi_rlast  = m_axi_rlast;
               s1_axi_ruser  = m_axi_ruser;
               s1_axi_rvalid = m_axi_rvalid;
               m_axi_rready  = s1_axi_rready;
            end else begin
               s0_axi_rid    = m_axi_rid;
               s0_axi_rdata  = m_axi_rdata;
               s0_axi_rresp  = m_axi_rresp;
               s0_axi_rlast  = m_axi_rlast;
               s0_axi_ruser  = m_axi_ruser;
               s0_axi_rvalid = m_axi_rvalid;
               m_axi_rready  = s0_axi_rready;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_len_q_nxt    = r_len_q;
      w_beat_cnt_nxt = r_beat_cnt;
      w_len_err_nxt  = r_len_err;
      case (r_state)
         ARB_IDLE: begin
            if (|w_req) begin
               w_owner_nxt    = w_gnt_idx;
               w_len_q_nxt    = w_gnt_idx ? s1_axi_arlen : s0_axi_arlen;
               w_beat_cnt_nxt = 8'd0;
               w_state_nxt    = ARB_AR;
            end
         end
         ARB_AR: begin
            if (w_ar_hs) begin
               w_state_nxt = ARB_R;
            end
         end
         ARB_R: begin
            if (w_r_hs) begin
               w_beat_cnt_nxt = r_beat_cnt + 8'd1;
               // Flags both an early RLAST and a missing one on the final beat.
               if (m_axi_rlast != (r_beat_cnt == r_len_q)) begin
                  w_len_err_nxt = 1'b1;
               end
               if (m_axi_rlast) begin
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_owner    <= 1'b1;
         r_beat_cnt <= 8'd0;
         r_len_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_len_err  <= w_len_err_nxt;
      end
   end

   // Burst length is only read after being loaded in ARB_IDLE.
   always_ff @(posedge clk) begin
      r_len_q <= w_len_q_nxt;
   end

   assign busy    = (r_state != ARB_IDLE);
   assign owner   = r_owner;
   assign len_err = r_len_err;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Directed bench for axi_rd_arbiter_2to1: behavioural slave and master monitors,
// a table of arbitration scenarios, and hand-written multi-cycle corner cases.
module tb_axi_rd_arbiter_2to1;

   localparam logic [9:0] ID0 = 10'h0A5;
   localparam logic [9:0] ID1 = 10'h3C2;

   logic        clk, rst;
   logic [9:0]  s0_axi_arid, s1_axi_arid, m_axi_arid;
   logic [63:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
   logic [7:0]  s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
   logic [2:0]  s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
   logic [1:0]  s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
   logic [5:0]  s0_axi_aruser, s1_axi_aruser, m_axi_aruser;
   logic        s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
   logic        s0_axi_arready, s1_axi_arready, m_axi_arready;
   logic [9:0]  s0_axi_rid, s1_axi_rid, m_axi_rid;
   logic [63:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
   logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
   logic        s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
   logic [5:0]  s0_axi_ruser, s1_axi_ruser, m_axi_ruser;
   logic        s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
   logic        s0_axi_rready, s1_axi_rready, m_axi_rready;
   logic        busy, owner, len_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          slv_early = 0;
   bit          slv_kill  = 0;
   bit          bp_mode   = 0;
   logic [63:0] rx0_d[$], rx1_d[$];
   logic [9:0]  rx0_id[$], rx1_id[$];
   logic        glog[$];

   axi_rd_arbiter_2to1 #(.ID_WIDTH(10), .ADDR_WIDTH(64), .DATA_WIDTH(64), .USER_WIDTH(6)) dut (
      .clk(clk), .rst(rst),
      .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
      .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_aruser(s0_axi_aruser),
      .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
      .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
      .s0_axi_rlast(s0_axi_rlast), .s0_axi_ruser(s0_axi_ruser), .s0_axi_rvalid(s0_axi_rvalid),
      .s0_axi_rready(s0_axi_rready),
      .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
      .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_aruser(s1_axi_aruser),
      .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
      .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
      .s1_axi_rlast(s1_axi_rlast), .s1_axi_ruser(s1_axi_ruser), .s1_axi_rvalid(s1_axi_rvalid),
      .s1_axi_rready(s1_axi_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready),
      .busy(busy), .owner(owner), .len_err(len_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave: accepts AR, returns len+1 beats (or slv_early beats) with data = addr + beat.
   initial begin : slave_model
      logic [7:0]  len;
      logic [63:0] addr;
      logic [9:0]  id;
      logic [5:0]  user;
      int          nb, beat;
      bit          hs;
      forever begin
         @(negedge clk);
         if (m_axi_arvalid && m_axi_arready && !rst) begin
            len  = m_axi_arlen;
            addr = m_axi_araddr;
            id   = m_axi_arid;
            user = m_axi_aruser;
            nb   = (slv_early != 0) ? slv_early : int'(len) + 1;
            @(posedge clk); #1;
            beat = 0;
            while (beat < nb) begin
               m_axi_rvalid = 1'b1;
               m_axi_rdata  = addr + 64'(beat);
               m_axi_rid    = id;
               m_axi_rresp  = 2'b00;
               m_axi_ruser  = user;
               m_axi_rlast  = (beat == nb - 1);
               @(negedge clk);
               if (slv_kill) break;
               hs = m_axi_rready;
               @(posedge clk); #1;
               if (hs) beat++;
            end
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
         end
      end
   end

   // Masters drop arvalid after their handshake.
   initial forever begin
      @(negedge clk);
      if (s0_axi_arvalid && s0_axi_arready) begin
         @(posedge clk); #1;
         s0_axi_arvalid = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (s1_axi_arvalid && s1_axi_arready) begin
         @(posedge clk); #1;
         s1_axi_arvalid = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (bp_mode) s0_axi_rready = ~s0_axi_rready;
      else         s0_axi_rready = 1'b1;
   end

   // Beat and grant logger.
   initial forever begin
      @(negedge clk);
      if (s0_axi_rvalid && s0_axi_rready) begin
         rx0_d.push_back(s0_axi_rdata);
         rx0_id.push_back(s0_axi_rid);
      end
      if (s1_axi_rvalid && s1_axi_rready) begin
         rx1_d.push_back(s1_axi_rdata);
         rx1_id.push_back(s1_axi_rid);
      end
      if (m_axi_arvalid && m_axi_arready) glog.push_back(owner);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_logs();
      rx0_d.delete(); rx1_d.delete(); rx0_id.delete(); rx1_id.delete(); glog.delete();
   endtask

   task automatic req(input bit m, input logic [63:0] addr, input logic [7:0] len);
      if (!m) begin
         s0_axi_araddr = addr; s0_axi_arlen = len; s0_axi_arid = ID0; s0_axi_arvalid = 1'b1;
      end else begin
         s1_axi_araddr = addr; s1_axi_arlen = len; s1_axi_arid = ID1; s1_axi_arvalid = 1'b1;
      end
   endtask

   task automatic wait_done(input string nm);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while ((s0_axi_arvalid || s1_axi_arvalid || busy || m_axi_rvalid) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " done"}, 64'(cyc < 300), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_rvalid(input string nm);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!m_axi_rvalid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " rvalid seen"}, 64'(cyc < 30), 64'd1);
   endtask

   task automatic check_burst(input string nm, input bit m, input logic [63:0] addr,
                              input logic [9:0] id, input int n);
      int sz;
      sz = m ? rx1_d.size() : rx0_d.size();
      check({nm, " beats"}, 64'(sz), 64'(n));
      for (int i = 0; i < n && i < sz; i++) begin
         check({nm, " data"}, m ? rx1_d[i] : rx0_d[i], addr + 64'(i));
         check({nm, " rid"}, 64'(m ? rx1_id[i] : rx0_id[i]), 64'(id));
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst owner", 64'(owner), 64'd1);
      check("rst len_err", 64'(len_err), 64'd0);
      check("rst m_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst m_rready", 64'(m_axi_rready), 64'd0);
      check("rst arready", 64'({s0_axi_arready, s1_axi_arready}), 64'd0);
      check("rst rvalid", 64'({s0_axi_rvalid, s1_axi_rvalid}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit         r0;
      bit         r1;
      logic [7:0] l0;
      logic [7:0] l1;
      bit         first;
      int         nb0;
      int         nb1;
   } vec_t;

   vec_t vt[6];

   initial begin
      int cyc;
      vt[0] = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 3, 2};
      vt[1] = '{1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1, 1};
      vt[2] = '{1'b0, 1'b1, 8'd0, 8'd4, 1'b1, 0, 5};
      vt[3] = '{1'b1, 1'b1, 8'd1, 8'd3, 1'b0, 2, 4};
      vt[4] = '{1'b1, 1'b0, 8'd5, 8'd0, 1'b0, 6, 0};
      vt[5] = '{1'b1, 1'b1, 8'd0, 8'd2, 1'b1, 1, 3};

      rst = 1'b1;
      s0_axi_arid = '0; s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arsize = 3'd3;
      s0_axi_arburst = 2'b01; s0_axi_aruser = 6'h15; s0_axi_arvalid = 1'b0;
      s1_axi_arid = '0; s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arsize = 3'd3;
      s1_axi_arburst = 2'b01; s1_axi_aruser = 6'h2A; s1_axi_arvalid = 1'b0;
      s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
      m_axi_arready = 1'b1; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_rlast = 1'b0; m_axi_ruser = '0; m_axi_rvalid = 1'b0;

      apply_reset();

      // single s0 request, arlen=3
      req(1'b0, 64'h1000, 8'd3);
      @(negedge clk);
      check("t1 no arvalid in IDLE", 64'(m_axi_arvalid), 64'd0);
      check("t1 no arready in IDLE", 64'(s0_axi_arready), 64'd0);
      @(negedge clk);
      check("t1 m_arvalid", 64'(m_axi_arvalid), 64'd1);
      check("t1 m_araddr", m_axi_araddr, 64'h1000);
      check("t1 m_arlen", 64'(m_axi_arlen), 64'd3);
      check("t1 m_aruser", 64'(m_axi_aruser), 64'h15);
      check("t1 busy", 64'(busy), 64'd1);
      wait_done("t1");
      check_burst("t1", 1'b0, 64'h1000, ID0, 4);
      check("t1 owner", 64'(owner), 64'd0);
      check("t1 busy after", 64'(busy), 64'd0);
      clear_logs();

      apply_reset();

      // arbitration table
      for (int i = 0; i < 6; i++) begin
         if (vt[i].r0) req(1'b0, 64'h2000 + 64'(i * 256), vt[i].l0);
         if (vt[i].r1) req(1'b1, 64'hA000_0000 + 64'(i * 256), vt[i].l1);
         wait_done($sformatf("v%0d", i));
         check($sformatf("v%0d grants", i), 64'(glog.size()), 64'(int'(vt[i].r0) + int'(vt[i].r1)));
         if (glog.size() > 0) check($sformatf("v%0d first", i), 64'(glog[0]), 64'(vt[i].first));
         if (glog.size() > 1) check($sformatf("v%0d second", i), 64'(glog[1]), 64'(!vt[i].first));
         if (vt[i].r0) check_burst($sformatf("v%0d s0", i), 1'b0, 64'h2000 + 64'(i * 256), ID0, vt[i].nb0);
         else          check($sformatf("v%0d s0 quiet", i), 64'(rx0_d.size()), 64'd0);
         if (vt[i].r1) check_burst($sformatf("v%0d s1", i), 1'b1, 64'hA000_0000 + 64'(i * 256), ID1, vt[i].nb1);
         else          check($sformatf("v%0d s1 quiet", i), 64'(rx1_d.size()), 64'd0);
         clear_logs();
      end

      // s1 arrives during an s0 burst
      req(1'b0, 64'h3000, 8'd7);
      wait_rvalid("t3");
      @(posedge clk); #1;
      req(1'b1, 64'h4000, 8'd2);
      repeat (2) begin
         @(negedge clk);
         check("t3 s1_arready held", 64'(s1_axi_arready), 64'd0);
         check("t3 m_arvalid held", 64'(m_axi_arvalid), 64'd0);
         check("t3 s1_rvalid", 64'(s1_axi_rvalid), 64'd0);
         check("t3 s1_rdata", s1_axi_rdata, 64'd0);
      end
      cyc = 0;
      @(negedge clk);
      while (!(m_axi_rvalid && m_axi_rready && m_axi_rlast) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("t3 rlast seen", 64'(cyc < 40), 64'd1);
      @(negedge clk);
      check("t3 idle busy", 64'(busy), 64'd0);
      check("t3 idle m_arvalid", 64'(m_axi_arvalid), 64'd0);
      @(negedge clk);
      check("t3 s1 m_arvalid", 64'(m_axi_arvalid), 64'd1);
      check("t3 s1 m_araddr", m_axi_araddr, 64'h4000);
      check("t3 s1 m_arid", 64'(m_axi_arid), 64'(ID1));
      check("t3 owner", 64'(owner), 64'd1);
      wait_done("t3");
      check_burst("t3 s0", 1'b0, 64'h3000, ID0, 8);
      check_burst("t3 s1", 1'b1, 64'h4000, ID1, 3);
      clear_logs();

      // backpressure on s0 rready
      req(1'b0, 64'h5000, 8'd5);
      bp_mode = 1'b1;
      wait_rvalid("t4");
      for (int i = 0; i < 6; i++) begin
         if (m_axi_rvalid) begin
            check("t4 m_rready tracks", 64'(m_axi_rready), 64'(s0_axi_rready));
            check("t4 s0_rvalid", 64'(s0_axi_rvalid), 64'd1);
         end
         @(negedge clk);
      end
      wait_done("t4");
      bp_mode = 1'b0;
      check_burst("t4", 1'b0, 64'h5000, ID0, 6);
      clear_logs();

      // early rlast on beat 2 of arlen=3
      check("t5 len_err clean", 64'(len_err), 64'd0);
      slv_early = 2;
      req(1'b0, 64'h6000, 8'd3);
      wait_done("t5");
      slv_early = 0;
      check("t5 len_err set", 64'(len_err), 64'd1);
      check("t5 busy", 64'(busy), 64'd0);
      check_burst("t5", 1'b0, 64'h6000, ID0, 2);
      clear_logs();
      req(1'b1, 64'h7000, 8'd0);
      wait_done("t5b");
      check("t5 len_err sticky", 64'(len_err), 64'd1);
      check_burst("t5b", 1'b1, 64'h7000, ID1, 1);
      clear_logs();

      // reset in the middle of an arlen=7 R burst
      req(1'b0, 64'h8000, 8'd7);
      wait_rvalid("t6");
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      slv_kill = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      check("t6 busy", 64'(busy), 64'd0);
      check("t6 owner", 64'(owner), 64'd1);
      check("t6 len_err", 64'(len_err), 64'd0);
      check("t6 m_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("t6 m_rready", 64'(m_axi_rready), 64'd0);
      check("t6 s0_rvalid", 64'(s0_axi_rvalid), 64'd0);
      @(posedge clk); #1;
      rst      = 1'b0;
      slv_kill = 1'b0;
      clear_logs();
      req(1'b0, 64'h9000, 8'd1);
      wait_done("t6b");
      check_burst("t6b", 1'b0, 64'h9000, ID0, 2);
      check("t6b owner", 64'(owner), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
